// File: rtl/writeback_64.sv
// writeback_64
// SEQ writeback stage and architectural register file for the Y86-64 datapath.
// Holds the 15 general registers, commits the E-port and M-port writes implied
// by the retiring instruction, serves two combinational read ports to decode and
// keeps a sticky processor status that freezes the register file once a
// non-AOK instruction retires.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   asynchronous active-high reset
//   wb_valid  in   1   retiring instruction is valid this cycle
//   icode     in   4   retiring instruction code
//   rA, rB    in   4   register specifier fields
//   cnd       in   1   condition outcome (cmovXX)
//   valE      in  64   execute result
//   valM      in  64   memory read result
//   stat_in   in   2   status of retiring instruction (00 AOK, 01 HLT, 10 ADR, 11 INS)
//   srcA/srcB in   4   read port register IDs (4'hF = RNONE reads zero)
//   rdA/rdB   out 64   register contents for srcA/srcB
//   halted    out  1   sticky stop indication
//   stat_out  out  2   architectural status

module writeback_64 #(
    parameter int         NREG   = 15,
    parameter logic [3:0] RSP_ID = 4'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [1:0]  stat_in,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] rdA,
    output logic [63:0] rdB,
    output logic        halted,
    output logic [1:0]  stat_out
);

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [1:0] STAT_AOK = 2'b00;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [1:0]  r_stat;
    logic [1:0]  w_statNext;
    logic [63:0] r_regs [NREG];

    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic        w_commit;
    logic [63:0] w_rdA;
    logic [63:0] w_rdB;

    // Destination decode: which register each write port targets for the
    // retiring instruction. A conditional move that fails its test writes nothing.
    always_comb begin
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (icode)
            4'h2:             w_dstE = cnd ? rB : RNONE;
            4'h3, 4'h6:       w_dstE = rB;
            4'h5:             w_dstM = rA;
            4'h8, 4'h9, 4'hA: w_dstE = RSP_ID;
            4'hB: begin
                w_dstE = RSP_ID;
                w_dstM = rA;
            end
            default: begin
                w_dstE = RNONE;
                w_dstM = RNONE;
            end
        endcase
    end

    // Only a valid AOK instruction retiring while running may touch registers;
    // the halting/faulting instruction itself is excluded by the stat_in test.
    assign w_commit = wb_valid && (r_state == ST_RUN) && (stat_in == STAT_AOK);

    // Register file. The M port is tested first so that popq %rsp keeps the
    // popped value rather than the incremented stack pointer. ID 15 matches no
    // entry, so RNONE writes fall away naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NREG; i++) begin
                if (w_dstM == 4'(i)) begin
                    r_regs[i] <= valM;
                end else if (w_dstE == 4'(i)) begin
                    r_regs[i] <= valE;
                end
            end
        end
    end

    // Read ports: plain lookup with no bypass, so a same-cycle write is not seen
    // until after the edge. RNONE matches no entry and reads zero.
    always_comb begin
        w_rdA = '0;
        w_rdB = '0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == 4'(i)) begin
                w_rdA = r_regs[i];
            end
            if (srcB == 4'(i)) begin
                w_rdB = r_regs[i];
            end
        end
    end

    assign rdA = w_rdA;
    assign rdB = w_rdB;

    // Status state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_stat  <= STAT_AOK;
        end else begin
            r_state <= w_stateNext;
            r_stat  <= w_statNext;
        end
    end

    // Status next-state: the first valid non-AOK retirement latches its status
    // and parks the machine in HALTED until reset.
    always_comb begin
        w_stateNext = r_state;
        w_statNext  = r_stat;
        case (r_state)
            ST_RUN: begin
                if (wb_valid && (stat_in != STAT_AOK)) begin
                    w_stateNext = ST_HALTED;
                    w_statNext  = stat_in;
                end
            end
            ST_HALTED: begin
                w_stateNext = ST_HALTED;
            end
            default: begin
                w_stateNext = ST_RUN;
            end
        endcase
    end

    assign halted   = (r_state == ST_HALTED);
    assign stat_out = r_stat;

endmodule

// File: tb/tb_writeback_64.sv
// tb_writeback_64
// Directed bench for writeback_64. A behavioural register-file model is
// updated on every rising edge from the instruction semantics and compared
// against the read ports and status on every falling edge; directed literal
// checks pin the model at key points.

module tb_writeback_64;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbValid;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [1:0]  statIn;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] rdA;
    logic [63:0] rdB;
    logic        halted;
    logic [1:0]  statOut;

    int checkCount = 0;
    int errorCount = 0;

    // Model state
    logic [63:0] mdlRegs [16];
    logic        mdlHalted;
    logic [1:0]  mdlStat;

    writeback_64 dut (
        .clk      (clk),
        .reset    (reset),
        .wb_valid (wbValid),
        .icode    (icode),
        .rA       (rA),
        .rB       (rB),
        .cnd      (cnd),
        .valE     (valE),
        .valM     (valM),
        .stat_in  (statIn),
        .srcA     (srcA),
        .srcB     (srcB),
        .rdA      (rdA),
        .rdB      (rdB),
        .halted   (halted),
        .stat_out (statOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a register array indexed by ID; index 15 is never
    // written so it always reads zero. M write follows E write so M wins.
    always @(posedge clk or posedge reset) begin
        logic [3:0] dE;
        logic [3:0] dM;
        if (reset) begin
            for (int i = 0; i < 16; i++) mdlRegs[i] = '0;
            mdlHalted = 1'b0;
            mdlStat   = 2'b00;
        end else if (!mdlHalted && wbValid) begin
            if (statIn != 2'b00) begin
                mdlHalted = 1'b1;
                mdlStat   = statIn;
            end else begin
                dE = 4'hF;
                dM = 4'hF;
                if (icode == 4'h2 && cnd)                dE = rB;
                if (icode == 4'h3 || icode == 4'h6)      dE = rB;
                if (icode == 4'h5)                       dM = rA;
                if (icode inside {4'h8, 4'h9, 4'hA})     dE = 4'd4;
                if (icode == 4'hB) begin
                    dE = 4'd4;
                    dM = rA;
                end
                if (dE != 4'hF) mdlRegs[dE] = valE;
                if (dM != 4'hF) mdlRegs[dM] = valM;
            end
        end
    end

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("rdA", rdA, mdlRegs[srcA]);
            checkOutput("rdB", rdB, mdlRegs[srcB]);
            checkOutput("halted", {63'd0, halted}, {63'd0, mdlHalted});
            checkOutput("stat_out", {62'd0, statOut}, {62'd0, mdlStat});
        end
    end

    // Present one retiring instruction shortly after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [3:0] ic, input logic [3:0] a,
                                 input logic [3:0] b, input logic c, input logic [63:0] e,
                                 input logic [63:0] m, input logic [1:0] st);
        @(posedge clk);
        #2;
        wbValid = v;
        icode   = ic;
        rA      = a;
        rB      = b;
        cnd     = c;
        valE    = e;
        valM    = m;
        statIn  = st;
    endtask

    // Let the previously presented instruction commit, then wait to mid-cycle.
    task automatic settle();
        applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, '0, '0, 2'b00);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        wbValid = 1'b0;
        icode   = 4'h1;
        rA      = 4'hF;
        rB      = 4'hF;
        cnd     = 1'b0;
        valE    = '0;
        valM    = '0;
        statIn  = 2'b00;
        srcA    = 4'd2;
        srcB    = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_halted", {63'd0, halted}, 64'd0);
        checkOutput("reset_stat", {62'd0, statOut}, 64'd0);
        checkOutput("reset_rdA", rdA, 64'd0);
        #1 reset = 1'b0;

        // irmovq into R2
        applyStimulus(1'b1, 4'h3, 4'hF, 4'd2, 1'b0, 64'h1234, 64'h0, 2'b00);
        settle();
        checkOutput("irmovq_R2", rdA, 64'h1234);
        srcA = 4'hF;
        #1 checkOutput("rnone_read", rdA, 64'h0);

        // cmovXX not taken, then taken
        srcA = 4'd5;
        applyStimulus(1'b1, 4'h2, 4'hF, 4'd5, 1'b0, 64'hAA, 64'h0, 2'b00);
        settle();
        checkOutput("cmov_nottaken", rdA, 64'h0);
        applyStimulus(1'b1, 4'h2, 4'hF, 4'd5, 1'b1, 64'hAA, 64'h0, 2'b00);
        settle();
        checkOutput("cmov_taken", rdA, 64'hAA);

        // popq %rbx-style, then popq %rsp (M port wins)
        srcA = 4'd4;
        srcB = 4'd3;
        applyStimulus(1'b1, 4'hB, 4'd3, 4'hF, 1'b0, 64'h108, 64'hDEAD, 2'b00);
        settle();
        checkOutput("popq_rsp", rdA, 64'h108);
        checkOutput("popq_rA", rdB, 64'hDEAD);
        applyStimulus(1'b1, 4'hB, 4'd4, 4'hF, 1'b0, 64'h110, 64'h77, 2'b00);
        settle();
        checkOutput("popq_rsp_self", rdA, 64'h77);

        // Read during write: old value before the edge, new value after
        srcB = 4'd6;
        applyStimulus(1'b1, 4'h6, 4'd1, 4'd6, 1'b0, 64'h9, 64'h0, 2'b00);
        #1 checkOutput("rdB_old", rdB, 64'h0);
        settle();
        checkOutput("rdB_new", rdB, 64'h9);

        // Assorted codes: call/push/ret hit %rsp, mrmovq uses M, others write nothing
        applyStimulus(1'b1, 4'h8, 4'hF, 4'hF, 1'b0, 64'h200, 64'h1, 2'b00);
        applyStimulus(1'b1, 4'h4, 4'd6, 4'd6, 1'b1, 64'h300, 64'h2, 2'b00);
        applyStimulus(1'b1, 4'h5, 4'd7, 4'd6, 1'b0, 64'h400, 64'hBEEF, 2'b00);
        applyStimulus(1'b1, 4'h7, 4'd7, 4'd7, 1'b1, 64'h500, 64'h3, 2'b00);
        applyStimulus(1'b1, 4'hA, 4'd1, 4'hF, 1'b0, 64'h1F8, 64'h4, 2'b00);
        applyStimulus(1'b1, 4'hC, 4'd8, 4'd8, 1'b1, 64'h600, 64'h5, 2'b00);
        applyStimulus(1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'h700, 64'h6, 2'b00);
        srcB = 4'd7;
        settle();
        checkOutput("seq_rsp", rdA, 64'h1F8);
        checkOutput("seq_mrmovq", rdB, 64'hBEEF);
        srcA = 4'd6;
        srcB = 4'd8;
        #1;
        checkOutput("seq_rmmovq_none", rdA, 64'h9);
        checkOutput("seq_badcode_none", rdB, 64'h0);

        // Halt: R1 = 5, then a HLT-status irmovq must not write
        srcA = 4'd1;
        applyStimulus(1'b1, 4'h3, 4'hF, 4'd1, 1'b0, 64'h5, 64'h0, 2'b00);
        applyStimulus(1'b1, 4'h3, 4'hF, 4'd1, 1'b0, 64'hFF, 64'h0, 2'b01);
        settle();
        checkOutput("halt_R1", rdA, 64'h5);
        checkOutput("halt_flag", {63'd0, halted}, 64'd1);
        checkOutput("halt_stat", {62'd0, statOut}, 64'd1);
        applyStimulus(1'b1, 4'h3, 4'hF, 4'd1, 1'b0, 64'h99, 64'h0, 2'b00);
        applyStimulus(1'b1, 4'h0, 4'hF, 4'd1, 1'b0, 64'h98, 64'h0, 2'b10);
        settle();
        checkOutput("halted_frozen", rdA, 64'h5);
        checkOutput("halted_stat_kept", {62'd0, statOut}, 64'd1);

        // Async reset while halted, holding a write across the edge
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("areset_halted", {63'd0, halted}, 64'd0);
        checkOutput("areset_stat", {62'd0, statOut}, 64'd0);
        checkOutput("areset_rdA", rdA, 64'h0);
        wbValid = 1'b1;
        icode   = 4'h3;
        rB      = 4'd1;
        valE    = 64'h55;
        statIn  = 2'b00;
        @(posedge clk);
        #2;
        reset   = 1'b0;
        wbValid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("areset_write_dropped", rdA, 64'h0);

        // Normal operation resumes; ADR fault latches its status
        applyStimulus(1'b1, 4'h6, 4'hF, 4'd1, 1'b0, 64'h42, 64'h0, 2'b00);
        applyStimulus(1'b1, 4'h5, 4'd1, 4'hF, 1'b0, 64'h0, 64'h43, 2'b10);
        settle();
        checkOutput("resume_R1", rdA, 64'h42);
        checkOutput("adr_stat", {62'd0, statOut}, 64'd2);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
